// File: rtl/ide_pkg.sv
// Shared types and constants for the ATA PIO cycle engine: FSM state encoding,
// task-file register addresses and default PIO timing.
package ide_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACTIVE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    // {cs[1:0], da[2:0]} for the commonly used task-file registers
    localparam logic [4:0] ADDR_DATA    = 5'b10000;
    localparam logic [4:0] ADDR_STATUS  = 5'b10111;
    localparam logic [4:0] ADDR_CMD     = 5'b10111;
    localparam logic [4:0] ADDR_ALTSTAT = 5'b01110;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_ACTIVE_CYC = 3;
    localparam int DEF_HOLD_CYC   = 1;
    localparam int DEF_RECOV_CYC  = 1;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_TMO_CYC    = 255;

endpackage

// File: rtl/ide_phase_timer.sv
// Loadable down-counter timing each PIO phase; holds at zero and flags it.
module ide_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ide_pio.sv
// ATA PIO cycle engine: one register/data transfer per handshake with programmable
// setup/active/hold/recovery timing. Define IDE_PIO_IORDY_EN to honour IORDY wait states.
module ide_pio
    import ide_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int ACTIVE_CYC = DEF_ACTIVE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int RECOV_CYC  = DEF_RECOV_CYC,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TMO_CYC    = DEF_TMO_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [4:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_done,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [DATA_W-1:0] ide_data_in,
    output logic [DATA_W-1:0] ide_data_out,
    output logic              ide_data_oe,
    output logic              ide_dior,
    output logic              ide_diow,
    output logic [1:0]        ide_cs,
    output logic [2:0]        ide_da,
    input  logic              ide_iordy
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LD = CNT_W'(ACTIVE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [4:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              load, tmr_zero, accept, act_exit, tmo_hit, busy;
    logic [CNT_W-1:0]  load_val;

`ifdef IDE_PIO_IORDY_EN
    localparam int              EXT_W   = $clog2(TMO_CYC + 1);
    localparam logic [EXT_W-1:0] TMO_LIM = EXT_W'(TMO_CYC);

    logic             iordy_meta_q, iordy_meta_d;
    logic             iordy_sync_q, iordy_sync_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic             err_q, err_d;
`else
    logic             iordy_unused;
    assign iordy_unused = ide_iordy;
`endif

    ide_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (tmr_zero)
    );

    // The last RECOVER clock already counts as idle, so a waiting command is taken
    // there; accept-to-accept is then exactly SETUP+ACTIVE+HOLD+RECOV clocks.
    assign cmd_ready = (state_q == IDLE) || ((state_q == RECOVER) && tmr_zero);

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        accept   = 1'b0;
        act_exit = 1'b0;
        tmo_hit  = 1'b0;
        rsp_done = 1'b0;
`ifdef IDE_PIO_IORDY_EN
        ext_d        = ext_q;
        iordy_meta_d = ide_iordy;
        iordy_sync_d = iordy_meta_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) accept = 1'b1;
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = ACTIVE;
                    load     = 1'b1;
                    load_val = ACTIVE_LD;
                end
            end
            ACTIVE: begin
                if (tmr_zero) begin
`ifdef IDE_PIO_IORDY_EN
                    if (iordy_sync_q || (ext_q == TMO_LIM)) begin
                        act_exit = 1'b1;
                        tmo_hit  = !iordy_sync_q;
                    end else begin
                        ext_d = ext_q + 1'b1;
                    end
`else
                    act_exit = 1'b1;
`endif
                end
                if (act_exit) begin
                    state_d  = HOLD;
                    load     = 1'b1;
                    load_val = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    rsp_done = 1'b1;
                    state_d  = RECOVER;
                    load     = 1'b1;
                    load_val = RECOV_LD;
                end
            end
            RECOVER: begin
                if (tmr_zero) begin
                    if (cmd_valid) accept = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = SETUP;
            load     = 1'b1;
            load_val = SETUP_LD;
`ifdef IDE_PIO_IORDY_EN
            ext_d    = '0;
`endif
        end

        wr_d    = accept ? cmd_wr    : wr_q;
        addr_d  = accept ? cmd_addr  : addr_q;
        wdata_d = accept ? cmd_wdata : wdata_q;
        din_d   = ide_data_in;
        rdata_d = (act_exit && !wr_q) ? din_q : rdata_q;
`ifdef IDE_PIO_IORDY_EN
        err_d = accept ? 1'b0 : ((act_exit && tmo_hit) ? 1'b1 : err_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 5'b11111;
            wdata_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
`ifdef IDE_PIO_IORDY_EN
            iordy_meta_q <= 1'b1;
            iordy_sync_q <= 1'b1;
            ext_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
`ifdef IDE_PIO_IORDY_EN
            iordy_meta_q <= iordy_meta_d;
            iordy_sync_q <= iordy_sync_d;
            ext_q        <= ext_d;
            err_q        <= err_d;
`endif
        end
    end

    // Pin decode uses only state and latched command fields
    assign busy         = (state_q == SETUP) || (state_q == ACTIVE) || (state_q == HOLD);
    assign ide_cs       = busy ? addr_q[4:3] : 2'b11;
    assign ide_da       = busy ? addr_q[2:0] : 3'b111;
    assign ide_dior     = !((state_q == ACTIVE) && !wr_q);
    assign ide_diow     = !((state_q == ACTIVE) && wr_q);
    assign ide_data_oe  = busy && wr_q;
    assign ide_data_out = (busy && wr_q) ? wdata_q : '0;
    assign rsp_rdata    = rdata_q;
`ifdef IDE_PIO_IORDY_EN
    assign rsp_err      = err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ide_pio.sv
// Directed self-checking bench for ide_pio: default-timing instance plus a slow-timing
// instance for back-to-back traffic. IORDY tests follow IDE_PIO_IORDY_EN.
module tb_ide_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [15:0] ide_data_in = '0;
    logic        ide_iordy = 1'b1;
    logic        cmd_ready, rsp_done, rsp_err, ide_data_oe, ide_dior, ide_diow;
    logic [15:0] rsp_rdata, ide_data_out;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;

    logic        v3 = 1'b0;
    logic [15:0] wd3 = 16'h0000;
    logic        ready3, done3, err3, oe3, dior3, diow3;
    logic [15:0] rdata3, dout3;
    logic [1:0]  cs3;
    logic [2:0]  da3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ide_pio #(.DATA_W(16), .TMO_CYC(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ide_data_in(ide_data_in), .ide_data_out(ide_data_out), .ide_data_oe(ide_data_oe),
        .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
        .ide_iordy(ide_iordy)
    );

    ide_pio #(.DATA_W(16), .SETUP_CYC(2), .ACTIVE_CYC(4), .HOLD_CYC(2), .RECOV_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(ready3),
        .cmd_wr(1'b1), .cmd_addr(5'b10000), .cmd_wdata(wd3),
        .rsp_done(done3), .rsp_rdata(rdata3), .rsp_err(err3),
        .ide_data_in(ide_data_in), .ide_data_out(dout3), .ide_data_oe(oe3),
        .ide_dior(dior3), .ide_diow(diow3), .ide_cs(cs3), .ide_da(da3),
        .ide_iordy(ide_iordy)
    );

    // Issues one command on dut and observes the pins once per clock until rsp_done.
    task automatic do_xfer(input logic wr, input logic [4:0] addr, input logic [15:0] wdata,
                           input int lo_from, input int lo_to,
                           output int done_at, output int rd_lo, output int wr_lo,
                           output int oe_cnt, output int dbad,
                           output logic [4:0] csda_st, output logic rdy1);
        done_at = -1; rd_lo = 0; wr_lo = 0; oe_cnt = 0; dbad = 0;
        csda_st = 5'b11111; rdy1 = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
        for (int n = 1; n <= 40 && done_at < 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cmd_valid = 1'b0; cmd_wr = !wr; cmd_addr = 5'b00000; cmd_wdata = ~wdata;
                rdy1 = cmd_ready;
            end
            if (n == lo_from) ide_iordy = 1'b0;
            if (n == lo_to)   ide_iordy = 1'b1;
            if (!ide_dior) rd_lo++;
            if (!ide_diow) wr_lo++;
            if ((!ide_dior || !ide_diow) && (rd_lo + wr_lo == 1)) csda_st = {ide_cs, ide_da};
            if (ide_data_oe) begin
                oe_cnt++;
                if (ide_data_out !== wdata) dbad++;
            end
            if (rsp_done) done_at = n;
        end
        ide_iordy = 1'b1;
        $display("[TB] xfer wr=%0b addr=%b done_at=%0d dior_lo=%0d diow_lo=%0d oe=%0d rdata=%h err=%0b",
                 wr, addr, done_at, rd_lo, wr_lo, oe_cnt, rsp_rdata, rsp_err);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({cmd_ready, rsp_done, rsp_err, ide_data_oe} !== 4'b1000) begin
            fails++; $display("FAIL reset_ctrl got=%b exp=1000", {cmd_ready, rsp_done, rsp_err, ide_data_oe});
        end
        tests++;
        if ({ide_dior, ide_diow, ide_cs, ide_da} !== 7'b1111111) begin
            fails++; $display("FAIL reset_pins got=%b exp=1111111", {ide_dior, ide_diow, ide_cs, ide_da});
        end
        tests++;
        if ({rsp_rdata, ide_data_out} !== 32'h0) begin
            fails++; $display("FAIL reset_data got=%h exp=00000000", {rsp_rdata, ide_data_out});
        end
        reset = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_read();
        int d, rl, wl, oc, db; logic [4:0] cd; logic r1;
        ide_data_in = 16'h0050;
        do_xfer(1'b0, 5'b10111, 16'h0000, -1, -1, d, rl, wl, oc, db, cd, r1);
        tests++; if (d !== 5) begin fails++; $display("FAIL read_latency got=%0d exp=5", d); end
        tests++; if (rl !== 3) begin fails++; $display("FAIL read_dior_lo got=%0d exp=3", rl); end
        tests++; if (wl !== 0) begin fails++; $display("FAIL read_diow_lo got=%0d exp=0", wl); end
        tests++; if (cd !== 5'b10111) begin fails++; $display("FAIL read_csda got=%b exp=10111", cd); end
        tests++; if (rsp_rdata !== 16'h0050) begin fails++; $display("FAIL read_data got=%h exp=0050", rsp_rdata); end
        tests++; if (oc !== 0) begin fails++; $display("FAIL read_oe got=%0d exp=0", oc); end
        tests++; if (r1 !== 1'b0) begin fails++; $display("FAIL read_ready_drop got=%b exp=0", r1); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL read_err got=%b exp=0", rsp_err); end
    endtask

    task automatic test_write();
        int d, rl, wl, oc, db; logic [4:0] cd; logic r1;
        ide_data_in = 16'h1234;
        do_xfer(1'b1, 5'b10000, 16'hA55A, -1, -1, d, rl, wl, oc, db, cd, r1);
        tests++; if (d !== 5) begin fails++; $display("FAIL write_latency got=%0d exp=5", d); end
        tests++; if (oc !== 5) begin fails++; $display("FAIL write_oe got=%0d exp=5", oc); end
        tests++; if (db !== 0) begin fails++; $display("FAIL write_data bad_cycles=%0d exp=0", db); end
        tests++; if (wl !== 3) begin fails++; $display("FAIL write_diow_lo got=%0d exp=3", wl); end
        tests++; if (rl !== 0) begin fails++; $display("FAIL write_dior_lo got=%0d exp=0", rl); end
        tests++; if (cd !== 5'b10000) begin fails++; $display("FAIL write_csda got=%b exp=10000", cd); end
        tests++; if (rsp_rdata !== 16'h0050) begin fails++; $display("FAIL write_rdata_kept got=%h exp=0050", rsp_rdata); end
        @(negedge clk);
        tests++; if (ide_data_out !== 16'h0000) begin fails++; $display("FAIL write_dout_idle got=%h exp=0000", ide_data_out); end
    endtask

    task automatic test_back_to_back();
        int acc = 0, wlo = 0, rlo = 0, csb = 0, ovl = 0;
        int acc_idx [4];
        @(negedge clk);
        v3 = 1'b1; wd3 = 16'h1111;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) @(negedge clk);
            if (acc == 3) v3 = 1'b0;
            if (ready3 && v3 && acc < 4) begin
                acc_idx[acc] = n; acc++;
                wd3 = wd3 + 16'h1111;
            end
            if (!diow3) wlo++;
            if (!dior3) rlo++;
            if (!diow3 && !dior3) ovl++;
            if (cs3 !== 2'b11) csb++;
        end
        $display("[TB] b2b accepts=%0d at %0d,%0d,%0d diow_lo=%0d cs_active=%0d", acc,
                 acc_idx[0], acc_idx[1], acc_idx[2], wlo, csb);
        tests++; if (acc !== 3) begin fails++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
        tests++;
        if (acc_idx[1] - acc_idx[0] !== 11 || acc_idx[2] - acc_idx[1] !== 11) begin
            fails++; $display("FAIL b2b_spacing got=%0d,%0d exp=11,11", acc_idx[1] - acc_idx[0], acc_idx[2] - acc_idx[1]);
        end
        tests++; if (wlo !== 12 || rlo !== 0 || ovl !== 0) begin
            fails++; $display("FAIL b2b_strobes diow_lo=%0d dior_lo=%0d overlap=%0d exp=12,0,0", wlo, rlo, ovl);
        end
        tests++; if (csb !== 24) begin fails++; $display("FAIL b2b_cs_active got=%0d exp=24", csb); end
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 5'b10000; cmd_wdata = 16'hBEEF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (ide_diow !== 1'b0) begin fails++; $display("FAIL abort_in_active got=%b exp=0", ide_diow); end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({ide_dior, ide_diow, ide_cs, ide_data_oe, rsp_done, cmd_ready} !== 7'b1111001) begin
            fails++; $display("FAIL abort_state got=%b exp=1111001",
                              {ide_dior, ide_diow, ide_cs, ide_data_oe, rsp_done, cmd_ready});
        end
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_done) dn++;
        end
        tests++; if (dn !== 0) begin fails++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
        $display("[TB] reset abort checked done_pulses=%0d", dn);
    endtask

`ifdef IDE_PIO_IORDY_EN
    task automatic test_iordy();
        int d, rl, wl, oc, db; logic [4:0] cd; logic r1;
        ide_data_in = 16'h0BAD;
        do_xfer(1'b0, 5'b10111, 16'h0000, 1, 7, d, rl, wl, oc, db, cd, r1);
        tests++; if (rl !== 8) begin fails++; $display("FAIL iordy_ext_dior_lo got=%0d exp=8", rl); end
        tests++; if (d !== 10) begin fails++; $display("FAIL iordy_ext_latency got=%0d exp=10", d); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL iordy_ext_err got=%b exp=0", rsp_err); end
        tests++; if (rsp_rdata !== 16'h0BAD) begin fails++; $display("FAIL iordy_ext_data got=%h exp=0bad", rsp_rdata); end
        ide_data_in = 16'h00D0;
        ide_iordy = 1'b0;
        do_xfer(1'b0, 5'b10111, 16'h0000, -1, -1, d, rl, wl, oc, db, cd, r1);
        tests++; if (rl !== 11) begin fails++; $display("FAIL iordy_tmo_dior_lo got=%0d exp=11", rl); end
        tests++; if (d !== 13) begin fails++; $display("FAIL iordy_tmo_latency got=%0d exp=13", d); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL iordy_tmo_err got=%b exp=1", rsp_err); end
        tests++; if (rsp_rdata !== 16'h00D0) begin fails++; $display("FAIL iordy_tmo_data got=%h exp=00d0", rsp_rdata); end
        do_xfer(1'b0, 5'b10111, 16'h0000, -1, -1, d, rl, wl, oc, db, cd, r1);
        tests++; if (rsp_err !== 1'b0 || d !== 5) begin
            fails++; $display("FAIL iordy_err_clear err=%b latency=%0d exp=0,5", rsp_err, d);
        end
    endtask
`else
    task automatic test_iordy_ignored();
        int d, rl, wl, oc, db; logic [4:0] cd; logic r1;
        ide_data_in = 16'h0050;
        ide_iordy = 1'b0;
        do_xfer(1'b0, 5'b10111, 16'h0000, -1, -1, d, rl, wl, oc, db, cd, r1);
        tests++; if (d !== 5) begin fails++; $display("FAIL noiordy_latency got=%0d exp=5", d); end
        tests++; if (rl !== 3) begin fails++; $display("FAIL noiordy_dior_lo got=%0d exp=3", rl); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL noiordy_err got=%b exp=0", rsp_err); end
    endtask
`endif

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_reset_abort();
`ifdef IDE_PIO_IORDY_EN
        test_iordy();
`else
        test_iordy_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
